// File: rtl/stim_pkg.sv
// Shared types, default constants and the Galois LFSR step function
// for the stimulus vector generator.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          LFSR_MAX_W   = 64;
    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    // Operates on a zero-extended value so any WIDTH up to LFSR_MAX_W can share it;
    // the low WIDTH bits of the result are the stepped register.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] lfsr,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return lfsr[0] ? ((lfsr >> 1) ^ taps) : (lfsr >> 1);
    endfunction

endpackage

// File: rtl/stim_lfsr_gen_lfsr_core.sv
// Galois LFSR register with load / advance / hold control.
// An all-zero load value would lock the LFSR, so it is replaced by DEFAULT_SEED.
module lfsr_core
    import stim_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = stim_pkg::DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = stim_pkg::DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0]      lfsr_reg;
    logic [WIDTH-1:0]      lfsr_step;
    logic [LFSR_MAX_W-1:0] step_wide;

    assign step_wide = lfsr_next(LFSR_MAX_W'(lfsr_reg), LFSR_MAX_W'(TAPS));
    assign lfsr_step = step_wide[WIDTH-1:0];

    generate
        if (WIDTH < LFSR_MAX_W) begin : g_pad
            logic unused_step_hi;
            assign unused_step_hi = &{1'b0, step_wide[LFSR_MAX_W-1:WIDTH]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= DEFAULT_SEED;
        end else if (load) begin
            lfsr_reg <= (load_value == '0) ? DEFAULT_SEED : load_value;
        end else if (advance) begin
            lfsr_reg <= lfsr_step;
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/stim_lfsr_gen.sv
// Stimulus source: streams LFSR vectors over a valid/ready handshake with a
// loadable seed and a programmable run length (0 = unbounded).
module stim_lfsr_gen
    import stim_pkg::*;
#(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   TAPS         = stim_pkg::DEFAULT_TAPS,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = stim_pkg::DEFAULT_SEED,
    parameter int                 COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vectors,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] vec_idx,
    output logic               busy,
    output logic               done
);

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] len_reg, len_next;
    logic [COUNT_W-1:0] idx_reg, idx_next;
    logic               lfsr_load;
    logic               lfsr_advance;
    logic               xfer;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .load_value (seed),
        .advance    (lfsr_advance),
        .value      (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
        end
    end

    // Outputs come from the state register only, so out_valid never
    // follows out_ready combinationally.
    assign out_valid = (state_reg == ST_RUN);
    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);
    assign vec_idx   = idx_reg;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        idx_next     = idx_reg;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                lfsr_load = seed_load;
                if (start) begin
                    state_next = ST_RUN;
                    len_next   = num_vectors;
                    idx_next   = '0;
                end
            end
            ST_RUN: begin
                lfsr_advance = xfer;
                if (xfer) begin
                    idx_next = idx_reg + COUNT_W'(1);
                    // Length 0 means unbounded: the index simply wraps.
                    if ((len_reg != '0) && (idx_reg == len_reg - COUNT_W'(1))) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stim_lfsr_gen.sv
// Self-checking bench for stim_lfsr_gen: directed runs from the test plan plus
// randomized runs checked against an arithmetic model of the LFSR stream.
module tb_stim_lfsr_gen;

    localparam int          WIDTH   = 32;
    localparam int          COUNT_W = 16;
    localparam logic [31:0] TAPS    = 32'h8020_0003;
    localparam logic [31:0] DSEED   = 32'hACE1_2468;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               seed_load;
    logic [WIDTH-1:0]   seed;
    logic               start;
    logic [COUNT_W-1:0] num_vectors;
    logic               out_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0] vec_idx;
    logic               busy;
    logic               done;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_lfsr;
    int          model_idx;
    logic [31:0] accepted[$];

    stim_lfsr_gen #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed_load   (seed_load),
        .seed        (seed),
        .start       (start),
        .num_vectors (num_vectors),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .vec_idx     (vec_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Polynomial division view: halve, and fold the taps back in when an odd value drops a one.
    function automatic logic [31:0] ref_step(input logic [31:0] v);
        if (v % 2 == 1) return (v / 2) ^ TAPS;
        return v / 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic do_load, input logic [31:0] s, input int n);
        seed_load   = do_load;
        seed        = s;
        start       = 1'b1;
        num_vectors = COUNT_W'(n);
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        if (do_load) model_lfsr = (s == 0) ? DSEED : s;
        model_idx = 0;
        accepted.delete();
    endtask

    // mode 0: always ready, 1: 4-cycle stall after first transfer, 2: random ready
    task automatic run_bounded(input int n, input int mode);
        int xfers = 0;
        int cyc   = 0;
        int stall = 0;
        logic rdy;
        while (xfers < n) begin
            if (cyc > 4000) begin
                check("run_timeout", 64'(xfers), 64'(n));
                return;
            end
            check("run_valid", 64'(out_valid), 64'd1);
            check("run_data", 64'(out_data), 64'(model_lfsr));
            check("run_idx", 64'(vec_idx), 64'(model_idx));
            rdy = 1'b1;
            if (mode == 1 && xfers == 1 && stall < 4) begin
                rdy = 1'b0;
                stall++;
            end
            if (mode == 2) rdy = ($urandom_range(0, 2) != 0);
            out_ready = rdy;
            tick();
            if (rdy) begin
                accepted.push_back(model_lfsr);
                model_lfsr = ref_step(model_lfsr);
                model_idx++;
                xfers++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        check("end_done", 64'(done), 64'd1);
        check("end_valid", 64'(out_valid), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        tick();
        check("after_valid", 64'(out_valid), 64'd0);
        check("after_data", 64'(out_data), 64'(model_lfsr));
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed = '0; start = 1'b0;
        num_vectors = '0; out_ready = 1'b0;
        model_lfsr = DSEED; model_idx = 0;
        #12 rst_n = 1'b1;
        repeat (5) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(out_data), 64'(32'hACE1_2468));
        check("rst_idx", 64'(vec_idx), 64'd0);

        // seed=1 loaded alone, then a 3-vector run
        seed_load = 1'b1; seed = 32'h1; tick(); seed_load = 1'b0;
        model_lfsr = 32'h1;
        check("seed1_data", 64'(out_data), 64'h1);
        begin_run(1'b0, 32'h0, 3);
        run_bounded(3, 0);
        check("run1_n", 64'(accepted.size()), 64'd3);
        if (accepted.size() == 3) begin
            check("run1_v0", 64'(accepted[0]), 64'(32'h0000_0001));
            check("run1_v1", 64'(accepted[1]), 64'(32'h8020_0003));
            check("run1_v2", 64'(accepted[2]), 64'(32'hC030_0002));
        end

        // restart from DONE without reload continues the sequence
        begin_run(1'b0, 32'h0, 2);
        check("cont_first", 64'(out_data), 64'(32'h6018_0001));
        run_bounded(2, 0);

        // seed_load and start together, with a 4-cycle stall
        begin_run(1'b1, 32'h1, 3);
        run_bounded(3, 1);
        check("stall_n", 64'(accepted.size()), 64'd3);
        if (accepted.size() == 3) begin
            check("stall_v1", 64'(accepted[1]), 64'(32'h8020_0003));
            check("stall_v2", 64'(accepted[2]), 64'(32'hC030_0002));
        end

        // zero seed is replaced by the default seed
        seed_load = 1'b1; seed = 32'h0; tick(); seed_load = 1'b0;
        model_lfsr = DSEED;
        check("zero_seed", 64'(out_data), 64'(32'hACE1_2468));
        check("zero_seed_done", 64'(done), 64'd1);

        // randomized bounded runs
        for (int r = 0; r < 8; r++) begin
            logic [31:0] s;
            int n;
            logic ld;
            s  = $urandom();
            n  = $urandom_range(1, 24);
            ld = ($urandom_range(0, 1) == 1);
            begin_run(ld, s, n);
            run_bounded(n, 2);
        end

        // unbounded run across the index wrap, with ignored seed_load/start pulses
        begin_run(1'b0, 32'h0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (i % 5000 == 0 || model_idx % 65536 >= 65534 || model_idx % 65536 <= 1 ||
                (i >= 100 && i <= 103)) begin
                check("unb_valid", 64'(out_valid), 64'd1);
                check("unb_done", 64'(done), 64'd0);
                check("unb_idx", 64'(vec_idx), 64'(model_idx % 65536));
                check("unb_data", 64'(out_data), 64'(model_lfsr));
            end
            seed_load = (i == 100);
            start     = (i == 101) || (i == 100);
            seed      = 32'h1234_5678;
            num_vectors = COUNT_W'(2);
            tick();
            model_lfsr = ref_step(model_lfsr);
            model_idx++;
        end
        seed_load = 1'b0; start = 1'b0;
        check("unb_end_busy", 64'(busy), 64'd1);
        check("unb_end_data", 64'(out_data), 64'(model_lfsr));

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_idx", 64'(vec_idx), 64'd0);
        check("arst_data", 64'(out_data), 64'(32'hACE1_2468));
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_data", 64'(out_data), 64'(32'hACE1_2468));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
